// File: rtl/ahbslv_mem.sv
// ahbslv_mem
// AHB slave memory. This is the responder for the DMA-style AHB master, and it
// also serves as the synthesizable scratch RAM. It accepts address phases,
// inserts P_WAIT wait states in each data phase, and performs little-endian,
// byte-lane-accurate accesses to a word-organised memory of 2^P_AW x 32 bits.
// Misaligned, oversized and out-of-range accesses get a two-cycle ERROR
// response.
//
// Ports:
//   I_AHBS_HCLK       clock, rising edge
//   I_AHBS_HRESET_N   synchronous active-low reset
//   I_AHBS_HSEL       slave select
//   I_AHBS_HADDR      byte address
//   I_AHBS_HTRANS     transfer type (IDLE/BUSY/NSEQ/SEQ)
//   I_AHBS_HWRITE     1 = write
//   I_AHBS_HSIZE      000 byte, 001 halfword, 010 word
//   I_AHBS_HBURST     burst type, captured only
//   I_AHBS_HWDATA     write data, data phase
//   I_AHBS_HREADY     system-wide ready
//   O_AHBS_HRDATA     read data (zero outside a read data phase)
//   O_AHBS_HREADYOUT  slave ready
//   O_AHBS_HRESP      00 OKAY, 01 ERROR
module ahbslv_mem #(
   parameter int unsigned P_AW   = 8,
   parameter logic [31:0] P_BASE = 32'h0000_0000,
   parameter int unsigned P_WAIT = 0
) (
   input  logic        I_AHBS_HCLK,
   input  logic        I_AHBS_HRESET_N,
   input  logic        I_AHBS_HSEL,
   input  logic [31:0] I_AHBS_HADDR,
   input  logic [1:0]  I_AHBS_HTRANS,
   input  logic        I_AHBS_HWRITE,
   input  logic [2:0]  I_AHBS_HSIZE,
   input  logic [2:0]  I_AHBS_HBURST,
   input  logic [31:0] I_AHBS_HWDATA,
   input  logic        I_AHBS_HREADY,
   output logic [31:0] O_AHBS_HRDATA,
   output logic        O_AHBS_HREADYOUT,
   output logic [1:0]  O_AHBS_HRESP
);

   localparam int unsigned DEPTH     = 1 << P_AW;
   localparam logic [3:0]  WAIT_LOAD = 4'((P_WAIT == 0) ? 0 : P_WAIT - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } state_t;

   state_t          state_q, state_d, accept_state;
   logic [3:0]      wcnt_q, wcnt_d;
   logic [P_AW-1:0] addr_q;
   logic            wr_q;
   logic [2:0]      size_q;
   logic [2:0]      burst_q;
   logic [3:0]      mask_q;
   logic [31:0]     mem [DEPTH];

   logic            can_accept;
   logic            accept;
   logic            in_range;
   logic            acc_err;
   logic [3:0]      lane_mask;

   // A new address phase is only sampled when no earlier data phase is
   // still stretching the bus. In ST_WAIT and ST_ERR1 the master holds the
   // address, so the slave ignores it there.
   assign can_accept = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
   assign accept     = can_accept & I_AHBS_HSEL & I_AHBS_HREADY & I_AHBS_HTRANS[1];
   assign in_range   = (I_AHBS_HADDR[31:P_AW+2] == P_BASE[31:P_AW+2]);

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      //       through the case leaves a value unassigned and infers a latch.
      acc_err   = !in_range;
      lane_mask = 4'b1111;
      case (I_AHBS_HSIZE)
         3'b000: lane_mask = 4'b0001 << I_AHBS_HADDR[1:0];
         3'b001: begin
            lane_mask = I_AHBS_HADDR[1] ? 4'b1100 : 4'b0011;
            if (I_AHBS_HADDR[0]) acc_err = 1'b1;
         end
         3'b010: if (I_AHBS_HADDR[1:0] != 2'b00) acc_err = 1'b1;
         default: acc_err = 1'b1;
      endcase
   end

   // Where a state that can take a new address phase goes next.
   always_comb begin
      accept_state = ST_IDLE;
      if (accept) begin
         if (acc_err)         accept_state = ST_ERR1;
         else if (P_WAIT > 0) accept_state = ST_WAIT;
         else                 accept_state = ST_DATA;
      end
   end

   always_comb begin
      state_d          = state_q;
      wcnt_d           = wcnt_q;
      O_AHBS_HREADYOUT = 1'b1;
      O_AHBS_HRESP     = 2'b00;
      case (state_q)
         ST_WAIT: begin
            O_AHBS_HREADYOUT = 1'b0;
            if (wcnt_q == 4'd0) state_d = ST_DATA;
            else                wcnt_d  = wcnt_q - 4'd1;
         end
         ST_ERR1: begin
            O_AHBS_HREADYOUT = 1'b0;
            O_AHBS_HRESP     = 2'b01;
            state_d          = ST_ERR2;
         end
         ST_ERR2: begin
            O_AHBS_HRESP = 2'b01;
            state_d      = accept_state;
            if (accept_state == ST_WAIT) wcnt_d = WAIT_LOAD;
         end
         default: begin
            state_d = accept_state;
            if (accept_state == ST_WAIT) wcnt_d = WAIT_LOAD;
         end
      endcase
   end

   always_ff @(posedge I_AHBS_HCLK) begin
      // NOTE: registers are updated with non-blocking assignments so every
      //       flop samples the pre-edge values regardless of statement order.
      if (!I_AHBS_HRESET_N) begin
         state_q <= ST_IDLE;
         wcnt_q  <= 4'd0;
         addr_q  <= '0;
         wr_q    <= 1'b0;
         size_q  <= 3'b000;
         burst_q <= 3'b000;
         mask_q  <= 4'b0000;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         if (accept) begin
            addr_q  <= I_AHBS_HADDR[P_AW+1:2];
            wr_q    <= I_AHBS_HWRITE;
            size_q  <= I_AHBS_HSIZE;
            burst_q <= I_AHBS_HBURST;
            mask_q  <= lane_mask;
         end
      end
   end

   // NOTE: the memory array has no reset so it maps onto plain RAM; only a
   //       pending write is cancelled when reset is asserted.
   always_ff @(posedge I_AHBS_HCLK) begin
      if (I_AHBS_HRESET_N && (state_q == ST_DATA) && wr_q) begin
         for (int i = 0; i < 4; i++) begin
            if (mask_q[i]) mem[addr_q][8*i +: 8] <= I_AHBS_HWDATA[8*i +: 8];
         end
      end
   end

   // The read is combinational from the captured address. A write retired in
   // the previous ST_DATA cycle is therefore already visible without a bypass.
   assign O_AHBS_HRDATA = ((state_q == ST_DATA) && !wr_q) ? mem[addr_q] : 32'h0;

   // Size and burst are captured for observability but steer no logic.
   logic unused_bits;
   assign unused_bits = ^{size_q, burst_q, I_AHBS_HTRANS[0]};

endmodule

// File: tb/tb_ahbslv_mem.sv
// Directed bench for ahbslv_mem. There are three instances with P_WAIT of 0, 2
// and 3. Each instance is driven by a small pipelined AHB master task, and
// expected values come from hand-computed vectors.
module tb_ahbslv_mem;

   localparam int NI = 3;

   logic        clk;
   logic        rst_n     [NI];
   logic        hsel      [NI];
   logic [31:0] haddr     [NI];
   logic [1:0]  htrans    [NI];
   logic        hwrite    [NI];
   logic [2:0]  hsize     [NI];
   logic [2:0]  hburst    [NI];
   logic [31:0] hwdata    [NI];
   logic        hblock    [NI];
   logic        hready    [NI];
   logic [31:0] hrdata    [NI];
   logic        hreadyout [NI];
   logic [1:0]  hresp     [NI];

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        wr;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rexp;
      logic        err;
   } beat_t;

   beat_t q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      assign hready[g] = hreadyout[g] & ~hblock[g];
      ahbslv_mem #(
         .P_AW  (8),
         .P_BASE(32'h0000_0000),
         .P_WAIT((g == 0) ? 0 : ((g == 1) ? 2 : 3))
      ) u_dut (
         .I_AHBS_HCLK     (clk),
         .I_AHBS_HRESET_N (rst_n[g]),
         .I_AHBS_HSEL     (hsel[g]),
         .I_AHBS_HADDR    (haddr[g]),
         .I_AHBS_HTRANS   (htrans[g]),
         .I_AHBS_HWRITE   (hwrite[g]),
         .I_AHBS_HSIZE    (hsize[g]),
         .I_AHBS_HBURST   (hburst[g]),
         .I_AHBS_HWDATA   (hwdata[g]),
         .I_AHBS_HREADY   (hready[g]),
         .O_AHBS_HRDATA   (hrdata[g]),
         .O_AHBS_HREADYOUT(hreadyout[g]),
         .O_AHBS_HRESP    (hresp[g])
      );
   end

   function automatic int pw(input int k);
      return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   task automatic add(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] rexp, input logic err);
      beat_t b;
      b.wr = wr; b.size = size; b.addr = addr; b.wdata = wdata; b.rexp = rexp; b.err = err;
      q.push_back(b);
   endtask

   // Pipelined master. Every action happens on the falling edge. When
   // HREADYOUT is high, the beat in its data phase completes at the next rising
   // edge, so it is checked here, and the next address is presented. Each beat
   // must show HRESP on every data cycle, exactly the expected number of
   // wait cycles, zero read data while stalled, and the expected HRDATA on its
   // last cycle. When exp_cycles is positive, the total cycle count from the
   // first address to the last completion is checked as well.
   task automatic run(input int k, input string tag, input int exp_cycles);
      int   nxt   = 0;
      int   dat   = -1;
      int   waits = 0;
      int   cyc   = 0;
      logic ro;
      while ((dat >= 0) || (nxt < q.size())) begin
         @(negedge clk);
         cyc++;
         if (cyc > 500) begin
            check($sformatf("%s_timeout", tag), 32'(cyc), 32'd500);
            break;
         end
         ro = hreadyout[k];
         if (dat >= 0) begin
            hwdata[k] = q[dat].wdata;
            check($sformatf("%s_b%0d_resp", tag, dat), 32'(hresp[k]), q[dat].err ? 32'd1 : 32'd0);
            if (!ro) begin
               waits++;
               check($sformatf("%s_b%0d_rd_stall", tag, dat), hrdata[k], 32'h0);
            end else begin
               check($sformatf("%s_b%0d_waits", tag, dat), 32'(waits), q[dat].err ? 32'd1 : 32'(pw(k)));
               check($sformatf("%s_b%0d_rdata", tag, dat), hrdata[k],
                     (q[dat].wr || q[dat].err) ? 32'h0 : q[dat].rexp);
               dat   = -1;
               waits = 0;
            end
         end
         if (ro) begin
            if (nxt < q.size()) begin
               hsel[k]   = 1'b1;
               htrans[k] = (nxt == 0) ? 2'b10 : 2'b11;
               haddr[k]  = q[nxt].addr;
               hwrite[k] = q[nxt].wr;
               hsize[k]  = q[nxt].size;
               dat       = nxt;
               nxt++;
            end else begin
               hsel[k]   = 1'b0;
               htrans[k] = 2'b00;
            end
         end
      end
      if (exp_cycles > 0) check($sformatf("%s_cycles", tag), 32'(cyc), 32'(exp_cycles));
      q.delete();
   endtask

   initial begin
      for (int k = 0; k < NI; k++) begin
         rst_n[k]  = 1'b0;
         hsel[k]   = 1'b0;
         haddr[k]  = 32'h0;
         htrans[k] = 2'b00;
         hwrite[k] = 1'b0;
         hsize[k]  = 3'b010;
         hburst[k] = 3'b000;
         hwdata[k] = 32'h0;
         hblock[k] = 1'b0;
      end
      repeat (2) @(negedge clk);
      for (int k = 0; k < NI; k++) begin
         check($sformatf("rst%0d_hreadyout", k), 32'(hreadyout[k]), 32'd1);
         check($sformatf("rst%0d_hresp", k), 32'(hresp[k]), 32'd0);
         check($sformatf("rst%0d_hrdata", k), hrdata[k], 32'h0);
         rst_n[k] = 1'b1;
      end

      // P_WAIT=0: basic word write/read, then several pipelined writes and reads back to back.
      add(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
      add(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
      run(0, "w0_word", 3);
      add(1'b1, 3'b010, 32'h00, 32'h600D_F00D, 32'h0, 1'b0);
      add(1'b1, 3'b010, 32'h40, 32'h1111_2222, 32'h0, 1'b0);
      run(0, "w0_fill", 3);

      // Byte and halfword lanes; a sub-word read still returns the full word.
      add(1'b1, 3'b000, 32'h13, 32'hAB00_0000, 32'h0, 1'b0);
      add(1'b0, 3'b010, 32'h10, 32'h0, 32'hABAD_BEEF, 1'b0);
      add(1'b1, 3'b001, 32'h12, 32'h1234_CAFE, 32'h0, 1'b0);
      add(1'b0, 3'b010, 32'h10, 32'h0, 32'h1234_BEEF, 1'b0);
      add(1'b0, 3'b000, 32'h11, 32'h0, 32'h1234_BEEF, 1'b0);
      run(0, "w0_lanes", 6);

      // Error cases. These are a misaligned halfword, out-of-range (P_BASE+0x400),
      // a misaligned word write and an illegal size. Each is followed by OKAY
      // reads taken in the ERR2 cycle, which prove memory is unchanged.
      add(1'b0, 3'b001, 32'h11,  32'h0, 32'h0, 1'b1);
      add(1'b1, 3'b010, 32'h400, 32'hFFFF_FFFF, 32'h0, 1'b1);
      add(1'b1, 3'b010, 32'h12,  32'h0000_0000, 32'h0, 1'b1);
      add(1'b0, 3'b011, 32'h10,  32'h0, 32'h0, 1'b1);
      add(1'b0, 3'b010, 32'h10,  32'h0, 32'h1234_BEEF, 1'b0);
      add(1'b0, 3'b010, 32'h00,  32'h0, 32'h600D_F00D, 1'b0);
      run(0, "w0_err", 11);

      // With HREADY held low by another slave, the NSEQ write must not be accepted.
      @(negedge clk);
      hblock[0] = 1'b1;
      hsel[0]   = 1'b1;
      htrans[0] = 2'b10;
      hwrite[0] = 1'b1;
      hsize[0]  = 3'b010;
      haddr[0]  = 32'h40;
      hwdata[0] = 32'h5555_5555;
      repeat (2) @(negedge clk);
      check("w0_hrdy_low_hreadyout", 32'(hreadyout[0]), 32'd1);
      check("w0_hrdy_low_hrdata", hrdata[0], 32'h0);
      hblock[0] = 1'b0;
      hsel[0]   = 1'b0;
      htrans[0] = 2'b00;
      add(1'b0, 3'b010, 32'h40, 32'h0, 32'h1111_2222, 1'b0);
      run(0, "w0_hrdy_low_read", 2);

      // P_WAIT=2: INCR4 write and read back, 4*3+1 = 13 cycles each.
      hburst[1] = 3'b011;
      for (int i = 0; i < 4; i++)
         add(1'b1, 3'b010, 32'h20 + 32'(4*i), 32'hA5A5_0000 + 32'(i*32'h0101), 32'h0, 1'b0);
      run(1, "w2_wr", 13);
      for (int i = 0; i < 4; i++)
         add(1'b0, 3'b010, 32'h20 + 32'(4*i), 32'h0, 32'hA5A5_0000 + 32'(i*32'h0101), 1'b0);
      run(1, "w2_rd", 13);
      // An error stays at two cycles whatever the wait setting: 1 + 2 + 3 = 6.
      add(1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 1'b1);
      add(1'b0, 3'b010, 32'h24, 32'h0, 32'hA5A5_0101, 1'b0);
      run(1, "w2_err", 6);

      // P_WAIT=3: establish 0 at 0x30, then reset during the second wait cycle of a write.
      add(1'b1, 3'b010, 32'h30, 32'h0000_0000, 32'h0, 1'b0);
      run(2, "w3_init", 5);
      @(negedge clk);
      check("w3_rst_start_ready", 32'(hreadyout[2]), 32'd1);
      hsel[2]   = 1'b1;
      htrans[2] = 2'b10;
      hwrite[2] = 1'b1;
      hsize[2]  = 3'b010;
      haddr[2]  = 32'h30;
      @(negedge clk);
      check("w3_rst_wait1", 32'(hreadyout[2]), 32'd0);
      hsel[2]   = 1'b0;
      htrans[2] = 2'b00;
      hwdata[2] = 32'hCAFE_F00D;
      @(negedge clk);
      check("w3_rst_wait2", 32'(hreadyout[2]), 32'd0);
      rst_n[2] = 1'b0;
      @(negedge clk);
      check("w3_rst_hreadyout", 32'(hreadyout[2]), 32'd1);
      check("w3_rst_hresp", 32'(hresp[2]), 32'd0);
      check("w3_rst_hrdata", hrdata[2], 32'h0);
      @(negedge clk);
      rst_n[2] = 1'b1;
      add(1'b0, 3'b010, 32'h30, 32'h0, 32'h0000_0000, 1'b0);
      run(2, "w3_after_rst", 5);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
